// File: rtl/ace_snoop_arbiter.sv
// Two-master coherent arbiter: grants one request at a time, snoops the peer,
// then runs a single memory access and returns data plus a shared indication.
module ace_snoop_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_shared,
    output logic [1:0]            snp_valid,
    output logic                  snp_inv,
    output logic [ADDR_W-1:0]     snp_addr,
    input  logic [1:0]            snp_ready,
    input  logic [1:0]            snp_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  grant_id,
    output logic                  busy,
    output logic [2:0]            curr_state,
    output logic                  snp_timeout_err,
    output logic [15:0]           txn_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNOOP = 3'd1,
        S_MEM   = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [7:0] TMO_LAST = 8'(SNOOP_TIMEOUT - 1);

    state_t            state_q, state_d;
    req_t              req_q, req_sel;
    logic              gnt_q, gnt_sel, ptr_q, hit_q, shared_q;
    logic [7:0]        tmo_q;
    logic [DATA_W-1:0] rdata_q;
    logic [15:0]       txn_q;
    logic              other, snp_ack, tmo_hit, accept;

    assign other   = ~gnt_q;
    assign snp_ack = snp_ready[other];
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Contention goes to the pointer; a lone requester wins outright.
    assign gnt_sel = (&req_valid) ? ptr_q : req_valid[1];

    always_comb begin
        req_sel.write = gnt_sel ? req_write[1] : req_write[0];
        req_sel.addr  = gnt_sel ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        req_sel.wdata = gnt_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    // Handshake only while out of reset so a held request never sees a stray ready.
    assign accept = (state_q == S_IDLE) && rst && (|req_valid);

    always_comb begin
        state_d         = state_q;
        req_ready       = 2'b00;
        snp_valid       = 2'b00;
        mem_req_valid   = 1'b0;
        rsp_valid       = 2'b00;
        snp_timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready[gnt_sel] = 1'b1;
                    state_d            = S_SNOOP;
                end
            end
            S_SNOOP: begin
                snp_valid[other] = 1'b1;
                if (snp_ack) begin
                    state_d = S_MEM;
                end else if (tmo_hit) begin
                    snp_timeout_err = 1'b1;
                    state_d         = S_MEM;
                end
            end
            S_MEM: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            gnt_q    <= 1'b0;
            ptr_q    <= 1'b0;
            hit_q    <= 1'b0;
            tmo_q    <= 8'd0;
            rdata_q  <= '0;
            shared_q <= 1'b0;
            txn_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        gnt_q <= gnt_sel;
                        req_q <= req_sel;
                    end
                end
                S_SNOOP: begin
                    if (snp_ack) begin
                        hit_q <= snp_hit[other];
                        tmo_q <= 8'd0;
                    end else if (tmo_hit) begin
                        hit_q <= 1'b0;
                        tmo_q <= 8'd0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q  <= req_q.write ? '0 : mem_rdata;
                        // A write invalidated the peer copy, so it is never shared.
                        shared_q <= hit_q & ~req_q.write;
                    end
                end
                S_RESP: begin
                    txn_q <= txn_q + 16'd1;
                    ptr_q <= ~gnt_q;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata     = rdata_q;
    assign rsp_shared    = shared_q;
    assign snp_inv       = req_q.write;
    assign snp_addr      = req_q.addr;
    assign mem_req_write = req_q.write;
    assign mem_addr      = req_q.addr;
    assign mem_wdata     = req_q.wdata;
    assign grant_id      = gnt_q;
    assign busy          = (state_q != S_IDLE);
    assign curr_state    = state_q;
    assign txn_count     = txn_q;

endmodule

// File: tb/tb_ace_snoop_arbiter.sv
// Directed bench for ace_snoop_arbiter with hand-computed expectations.
module tb_ace_snoop_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_shared;
    logic [1:0]  snp_valid;
    logic        snp_inv;
    logic [31:0] snp_addr;
    logic [1:0]  snp_ready, snp_hit;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        grant_id, busy, snp_timeout_err;
    logic [2:0]  curr_state;
    logic [15:0] txn_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rsp;

    ace_snoop_arbiter #(.ADDR_W(32), .DATA_W(32), .SNOOP_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_shared(rsp_shared),
        .snp_valid(snp_valid), .snp_inv(snp_inv), .snp_addr(snp_addr),
        .snp_ready(snp_ready), .snp_hit(snp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy), .curr_state(curr_state),
        .snp_timeout_err(snp_timeout_err), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with immediate snoop/memory handshakes; starts in IDLE.
    task automatic do_txn(input int m, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic hit, input logic [31:0] rd, input logic [1:0] exp_rdy,
                          input logic [1:0] exp_snp, input logic [1:0] exp_rsp,
                          input logic [31:0] exp_rdata, input logic exp_shared,
                          input logic [15:0] exp_cnt);
        req_valid    = 2'b00;
        req_valid[m] = 1'b1;
        req_write[m] = wr;
        if (m == 0) begin req_addr[31:0] = a; req_wdata[31:0] = wd; end
        else        begin req_addr[63:32] = a; req_wdata[63:32] = wd; end
        #1;
        chk("accept_ready", req_ready, exp_rdy);
        step();
        req_valid = 2'b00;
        req_addr  = '1;
        req_wdata = '1;
        snp_ready[1-m] = 1'b1;
        snp_hit[1-m]   = hit;
        #1;
        chk("snoop_valid", snp_valid, exp_snp);
        chk("snoop_inv", snp_inv, wr);
        chk("snoop_addr", snp_addr, a);
        step();
        snp_ready = 2'b00;
        mem_req_ready = 1'b1;
        #1;
        chk("mem_valid", mem_req_valid, 1'b1);
        chk("mem_write", mem_req_write, wr);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, wd);
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        #1;
        chk("wait_state", curr_state, 3'd3);
        step();
        mem_rsp_valid = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, exp_rsp);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_shared", rsp_shared, exp_shared);
        step();
        chk("txn_count", txn_count, exp_cnt);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        snp_ready = 2'b00; snp_hit = 2'b00;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

        // Reset state; a request held during reset must not be acknowledged.
        step(); step();
        req_valid = 2'b01;
        #1;
        chk("rst_state", curr_state, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_txn", txn_count, 16'd0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        req_valid = 2'b00;
        rst = 1'b1;
        step();

        // M0 read, peer hit -> shared.
        do_txn(0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'hCAFEF00D,
               2'b01, 2'b10, 2'b01, 32'hCAFEF00D, 1'b1, 16'd1);
        // M1 write, peer hit invalidated -> not shared, data reads back 0.
        do_txn(1, 1'b1, 32'h2000, 32'hDEAD, 1'b1, 32'hBEEF,
               2'b10, 2'b01, 2'b10, 32'h0, 1'b0, 16'd2);
        chk("grant_id_m1", grant_id, 1'b1);

        // Both masters requesting continuously from reset, all handshakes immediate.
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst2_txn", txn_count, 16'd0);
        snp_ready = 2'b11; snp_hit = 2'b00;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'h0000_B000, 32'h0000_A000};
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("rr_req_ready", req_ready,
                (c % 5 == 0) ? ((((c / 5) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00);
            chk("rr_rsp_valid", rsp_valid,
                (c % 5 == 4) ? ((((c / 5) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00);
            step();
        end
        req_valid = 2'b00;
        #1;
        chk("rr_txn", txn_count, 16'd4);
        snp_ready = 2'b00; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        step();

        // Snoop timeout: no peer ack, hit forced 0 even though snp_hit is high.
        snp_hit = 2'b11;
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h4000;
        #1;
        chk("tmo_accept", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            chk("tmo_snoop_state", curr_state, 3'd1);
            chk("tmo_err", snp_timeout_err, (k == 15) ? 1'b1 : 1'b0);
            step();
        end
        chk("tmo_mem_state", curr_state, 3'd2);
        chk("tmo_err_after", snp_timeout_err, 1'b0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h55;
        step();
        mem_rsp_valid = 1'b0;
        #1;
        chk("tmo_rsp_valid", rsp_valid, 2'b01);
        chk("tmo_rsp_shared", rsp_shared, 1'b0);
        chk("tmo_rsp_rdata", rsp_rdata, 32'h55);
        step();
        snp_hit = 2'b00;

        // Memory backpressure: M1 write held in MEM for 6 cycles, response 3 cycles later.
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[63:32] = 32'h3000; req_wdata[63:32] = 32'h1234;
        #1;
        chk("bp_accept", req_ready, 2'b10);
        step();
        req_valid = 2'b00; req_addr = '1; req_wdata = '1;
        snp_ready = 2'b01;
        #1;
        chk("bp_snp_valid", snp_valid, 2'b01);
        chk("bp_snp_inv", snp_inv, 1'b1);
        step();
        snp_ready = 2'b00;
        for (int k = 0; k < 7; k++) begin
            mem_req_ready = (k == 6);
            #1;
            chk("bp_mem_valid", mem_req_valid, 1'b1);
            chk("bp_mem_addr", mem_addr, 32'h3000);
            chk("bp_mem_wdata", mem_wdata, 32'h1234);
            step();
        end
        mem_req_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            mem_rsp_valid = (w == 2);
            mem_rdata = 32'h7777;
            #1;
            chk("bp_wait_state", curr_state, 3'd3);
            step();
        end
        mem_rsp_valid = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid[1]) n_rsp++;
            if (k == 0) chk("bp_rsp_rdata", rsp_rdata, 32'h0);
            step();
        end
        chk("bp_rsp_count", n_rsp, 1);

        // Reset during WAIT, then a stale memory response.
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h5000;
        snp_ready = 2'b10; snp_hit = 2'b10; mem_req_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        step();
        #1;
        chk("wr_in_wait", curr_state, 3'd3);
        rst = 1'b0;
        step();
        chk("wr_state", curr_state, 3'd0);
        chk("wr_busy", busy, 1'b0);
        chk("wr_txn", txn_count, 16'd0);
        chk("wr_snp_valid", snp_valid, 2'b00);
        chk("wr_mem_valid", mem_req_valid, 1'b0);
        chk("wr_rsp_valid", rsp_valid, 2'b00);
        chk("wr_grant", grant_id, 1'b0);
        chk("wr_mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        snp_ready = 2'b00; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hAAAA;
        step();
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stale_rsp_valid", rsp_valid, 2'b00);
            chk("stale_state", curr_state, 3'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ace_snoop_arbiter.md
Name: ace_snoop_arbiter

Overview:
Arbiter and sequencer that shares one downstream memory port between two cache-coherence controllers (masters 0 and 1). It serialises one transaction at a time. For each granted request it snoops the other master (a read probes the line; a write invalidates it), then issues the memory access and returns data plus a shared indication to the requester. It sits between the per-cache controller/datapath pairs and the common memory/interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
SNOOP_TIMEOUT, 15, max cycles in SNOOP waiting for snp_ready (range 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
req_valid  in  2  per-master request valid, bit i = master i
req_ready  out  2  per-master acceptance pulse
req_write  in  2  per-master 1=write, 0=read
req_addr  in  2*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  master i at [i*DATA_W +: DATA_W]
rsp_valid  out  2  per-master response pulse
rsp_rdata  out  DATA_W  response data, shared by both masters
rsp_shared  out  1  line is held by the other master after this access
snp_valid  out  2  snoop valid to master i
snp_inv  out  1  1=invalidate snoop (write), 0=probe (read)
snp_addr  out  ADDR_W  snoop address
snp_ready  in  2  snoop acknowledge from master i
snp_hit  in  2  line present in master i, sampled with snp_ready
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory request accept
mem_req_write  out  1  memory request type
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rsp_valid  in  1  memory completion/read data valid
mem_rdata  in  DATA_W  memory read data
grant_id  out  1  currently/last granted master
busy  out  1  high in every state except IDLE
curr_state  out  3  FSM state encoding
snp_timeout_err  out  1  one-cycle pulse on snoop timeout
txn_count  out  16  completed transactions, wraps 0xFFFF->0x0000

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE, all outputs 0, RR pointer favours master 0, timeout counter 0, txn_count 0. Reset mid-transaction aborts it. The next cycle shows no valids and no response is issued.
- FSM encoding: IDLE=0, SNOOP=1, MEM=2, WAIT=3, RESP=4.
- IDLE:
  - If exactly one req_valid is high, grant that master.
  - If both are high, grant the master not served last (pointer); after reset, master 0.
  - req_ready[g] is combinationally high in this cycle only, and the transfer occurs at this edge.
  - Register addr, write, wdata and grant_id; go to SNOOP.
- SNOOP:
  - snp_valid[~g]=1, snp_addr=captured addr, snp_inv=captured write.
  - On snp_ready[~g]: latch hit=snp_hit[~g], go to MEM.
  - Timeout counter increments each SNOOP cycle without snp_ready. When it reaches SNOOP_TIMEOUT: hit=0, snp_timeout_err pulses 1 cycle, go to MEM. The counter clears on leaving SNOOP.
  - snp_ready/snp_hit from master g are ignored.
- MEM:
  - mem_req_valid=1 with addr/write/wdata held stable until mem_req_ready, then go to WAIT.
  - No retraction.
- WAIT:
  - On mem_rsp_valid: latch mem_rdata (writes latch 0), go to RESP.
  - mem_rsp_valid outside WAIT is ignored.
- RESP (one cycle):
  - rsp_valid[g]=1, rsp_rdata=latched data, rsp_shared = hit & ~write. Writes always report 0 because the other copy was invalidated.
  - txn_count += 1; pointer := ~g; go to IDLE.
- Minimum latency: with all readies immediate, rsp_valid is asserted 4 cycles after the acceptance cycle. Back-to-back transactions need at least one IDLE cycle, giving 5-cycle throughput.
- Requests asserted outside IDLE wait; req_ready stays 0 and masters must hold req_valid.
- rsp_rdata, rsp_shared and snp_inv are meaningful only while the corresponding valid is high; they hold their last values otherwise.

Test Plan:
- Reset then M0 read 0x1000, snp_ready[1]=1 same cycle with snp_hit=1, mem ready immediate, mem_rdata=0xCAFEF00D -> req_ready[0] pulse, snp_valid[1] with snp_inv=0, rsp_valid[0] 4 cycles later, rdata=0xCAFEF00D, rsp_shared=1, txn_count=1.
- M1 write 0x2000 data 0xDEAD, snp_hit[0]=1 -> snp_inv=1, mem_req_write=1 with mem_wdata=0xDEAD, rsp_shared=0, rsp_rdata=0.
- Both masters request continuously from reset -> grants alternate 0,1,0,1, each response 5 cycles apart, txn_count=4 after four transactions.
- snp_ready never asserted, SNOOP_TIMEOUT=15 -> exactly 15 SNOOP cycles, snp_timeout_err single pulse, rsp_shared=0, transaction completes.
- mem_req_ready held low 6 cycles then high, mem_rsp_valid 3 cycles later -> mem_addr/wdata stable throughout, exactly one rsp_valid.
- rst=0 asserted during WAIT -> next cycle all outputs 0, curr_state=0. A stale mem_rsp_valid after reset produces no rsp_valid. txn_count wraps 0xFFFF->0 after 65536 transactions (preload via long run).
